// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C master byte sequencer and the bit writer
// that sits directly downstream of it.
//   - 3-bit bit-writer command codes
//   - byte-sequencer state enumeration
//   - helper mapping a data bit onto its bit-writer command
// ---------------------------------------------------------------------------
package i2c_pkg;

    // Bit-writer command encoding (shared with the bit writer).
    localparam logic [2:0] CMD_IDLE      = 3'b000;
    localparam logic [2:0] CMD_START_BIT = 3'b010;
    localparam logic [2:0] CMD_STOP_BIT  = 3'b011;
    localparam logic [2:0] CMD_DATA_0    = 3'b100;
    localparam logic [2:0] CMD_DATA_1    = 3'b101;
    localparam logic [2:0] CMD_ACK_BIT   = 3'b110;
    localparam logic [2:0] CMD_NACK_BIT  = 3'b111;

    // Byte-sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_DONE  = 3'd4
    } byte_state_t;

    // Command that transmits a single data bit.
    function automatic logic [2:0] data_cmd(input logic b);
        return b ? CMD_DATA_1 : CMD_DATA_0;
    endfunction

endpackage

// File: rtl/i2c_master_write_byte.sv
// ---------------------------------------------------------------------------
// i2c_master_write_byte
// Byte-level sequencer feeding the I2C master bit writer. Accepts one byte
// with framing flags and issues bit commands over the bit writer's
// go/command/finish handshake: optional START, 8 data bits MSB first,
// optional STOP. Signals completion with a one-cycle finish pulse.
//
// Ports:
//   clock        in   system clock
//   reset_n      in   asynchronous active-low reset
//   go           in   start request, sampled only in IDLE or DONE
//   data_in[7:0] in   byte to transmit, latched when go is accepted
//   with_start   in   prepend START bit (latched with go)
//   with_stop    in   append STOP bit (latched with go)
//   busy         out  high from the cycle after go is accepted through DONE
//   finish       out  one-cycle pulse, byte sequence complete
//   error        out  one-cycle pulse, bit writer timeout
//   bit_go       out  enable to the bit writer
//   bit_command  out  bit command to the bit writer
//   bit_finish   in   completion from the bit writer (high in its 8th cycle)
//
// Build option:
//   I2C_WRITE_BYTE_TIMEOUT_EN - adds a watchdog that aborts the byte when
//   bit_go stays high for TIMEOUT_CYCLES cycles without bit_finish.
//   Undefined: no watchdog, error is tied low.
// ---------------------------------------------------------------------------
module i2c_master_write_byte
    import i2c_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       go,
    input  logic [7:0] data_in,
    input  logic       with_start,
    input  logic       with_stop,
    output logic       busy,
    output logic       finish,
    output logic       error,
    output logic       bit_go,
    output logic [2:0] bit_command,
    input  logic       bit_finish
);

    byte_state_t state_q;
    logic [7:0]  shift_q;
    logic [2:0]  index_q;
    logic        stop_q;
    logic        busy_q;
    logic        finish_q;
    logic        bit_go_q;
    logic [2:0]  cmd_q;
    logic        accept;
    logic        wd_expire;

    // go is only honoured while no bit is in flight.
    assign accept = go && ((state_q == ST_IDLE) || (state_q == ST_DONE));

`ifdef I2C_WRITE_BYTE_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q;
    logic [WD_W-1:0] wd_d;
    logic            error_q;

    // Restart on every new bit (accept or bit_finish), count while bit_go.
    always_comb begin
        wd_d = '0;
        if (accept || (bit_go_q && bit_finish)) begin
            wd_d = '0;
        end else if (bit_go_q) begin
            wd_d = wd_q + 1'b1;
        end
    end

    // Fires on the edge where the count would reach TIMEOUT_CYCLES, so bit_go
    // has been high for exactly TIMEOUT_CYCLES cycles when it drops.
    assign wd_expire = bit_go_q && !bit_finish
                       && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wd_q    <= '0;
            error_q <= 1'b0;
        end else begin
            wd_q    <= wd_expire ? '0 : wd_d;
            error_q <= wd_expire;
        end
    end

    assign error = error_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign wd_expire          = 1'b0;
    assign error              = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            shift_q  <= 8'h00;
            index_q  <= 3'd0;
            stop_q   <= 1'b0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
            bit_go_q <= 1'b0;
            cmd_q    <= CMD_IDLE;
        end else begin
            finish_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    busy_q   <= 1'b0;
                    bit_go_q <= 1'b0;
                    cmd_q    <= CMD_IDLE;
                    state_q  <= ST_IDLE;
                    if (accept) begin
                        shift_q  <= data_in;
                        index_q  <= 3'd7;
                        stop_q   <= with_stop;
                        busy_q   <= 1'b1;
                        bit_go_q <= 1'b1;
                        if (with_start) begin
                            state_q <= ST_START;
                            cmd_q   <= CMD_START_BIT;
                        end else begin
                            state_q <= ST_DATA;
                            cmd_q   <= data_cmd(data_in[7]);
                        end
                    end
                end

                ST_START: begin
                    if (bit_finish) begin
                        state_q <= ST_DATA;
                        cmd_q   <= data_cmd(shift_q[7]);
                    end
                end

                ST_DATA: begin
                    if (bit_finish) begin
                        shift_q <= {shift_q[6:0], 1'b0};
                        index_q <= index_q - 3'd1;
                        if (index_q == 3'd0) begin
                            if (stop_q) begin
                                state_q <= ST_STOP;
                                cmd_q   <= CMD_STOP_BIT;
                            end else begin
                                state_q  <= ST_DONE;
                                bit_go_q <= 1'b0;
                                cmd_q    <= CMD_IDLE;
                                finish_q <= 1'b1;
                            end
                        end else begin
                            // shift_q[6] becomes the MSB once the shift lands.
                            cmd_q <= data_cmd(shift_q[6]);
                        end
                    end
                end

                ST_STOP: begin
                    if (bit_finish) begin
                        state_q  <= ST_DONE;
                        bit_go_q <= 1'b0;
                        cmd_q    <= CMD_IDLE;
                        finish_q <= 1'b1;
                    end
                end

                default: begin
                    state_q  <= ST_IDLE;
                    busy_q   <= 1'b0;
                    bit_go_q <= 1'b0;
                    cmd_q    <= CMD_IDLE;
                end
            endcase

            // Watchdog abort overrides whatever the bit state decided.
            if (wd_expire) begin
                state_q  <= ST_IDLE;
                busy_q   <= 1'b0;
                bit_go_q <= 1'b0;
                cmd_q    <= CMD_IDLE;
                finish_q <= 1'b0;
            end
        end
    end

    assign busy        = busy_q;
    assign finish      = finish_q;
    assign bit_go      = bit_go_q;
    assign bit_command = cmd_q;

endmodule

// File: tb/tb_i2c_master_write_byte.sv
// ---------------------------------------------------------------------------
// tb_i2c_master_write_byte
// Directed bench for the I2C byte sequencer. A small model of the bit writer
// raises bit_finish in the 8th cycle of bit_go. Outputs are sampled on the
// falling clock edge; inputs are driven on the falling edge.
// Observed vector per cycle: {busy, finish, error, bit_go, bit_command}.
// ---------------------------------------------------------------------------
module tb_i2c_master_write_byte;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       go = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       with_start = 1'b0;
    logic       with_stop = 1'b0;
    logic       busy;
    logic       finish;
    logic       error;
    logic       bit_go;
    logic [2:0] bit_command;
    logic       bit_finish;

    int tests_run    = 0;
    int tests_failed = 0;

    // Bit writer model controls.
    logic [2:0] bw_cnt;
    logic       bw_stall  = 1'b0;
    logic       bw_inject = 1'b0;

    always #5 clock = ~clock;

    i2c_master_write_byte #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .go         (go),
        .data_in    (data_in),
        .with_start (with_start),
        .with_stop  (with_stop),
        .busy       (busy),
        .finish     (finish),
        .error      (error),
        .bit_go     (bit_go),
        .bit_command(bit_command),
        .bit_finish (bit_finish)
    );

    // Bit writer model: counts cycles of bit_go, finish in the 8th.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bw_cnt <= 3'd0;
        end else if (bit_go) begin
            bw_cnt <= bw_cnt + 3'd1;
        end else begin
            bw_cnt <= 3'd0;
        end
    end

    assign bit_finish = (bit_go && (bw_cnt == 3'd7) && !bw_stall) || bw_inject;

    function automatic logic [6:0] obs();
        return {busy, finish, error, bit_go, bit_command};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs from the cycle after the accept edge through the DONE cycle.
    // hold_go keeps go high; next_data is driven in cycle 2; pulse_at > 0
    // pulses go with 8'h3C while the byte is in flight.
    task automatic expect_byte(input string tag, input logic [2:0] cmds [10],
                               input int nbits, input bit hold_go,
                               input logic [7:0] next_data, input int pulse_at);
        for (int k = 1; k <= 8 * nbits; k++) begin
            @(negedge clock);
            check_eq($sformatf("%s_c%0d", tag, k), 32'(obs()),
                     32'({1'b1, 1'b0, 1'b0, 1'b1, cmds[(k - 1) / 8]}));
            if (k == 1 && !hold_go) go = 1'b0;
            if (k == 2) data_in = next_data;
            if (pulse_at > 0 && k == pulse_at) begin
                go      = 1'b1;
                data_in = 8'h3C;
            end
            if (pulse_at > 0 && k == pulse_at + 1) go = 1'b0;
        end
        @(negedge clock);
        check_eq($sformatf("%s_done", tag), 32'(obs()), 32'(7'b1100_000));
        $display("[TB] %s: %0d bit commands, finish at cycle %0d", tag, nbits,
                 8 * nbits + 1);
    endtask

    task automatic start_byte(input logic [7:0] d, input logic ws, input logic wp);
        @(negedge clock);
        go         = 1'b1;
        data_in    = d;
        with_start = ws;
        with_stop  = wp;
    endtask

    logic [2:0] seq_a5   [10];
    logic [2:0] seq_00   [10];
    logic [2:0] seq_ff   [10];
    logic [2:0] seq_01   [10];
    logic [2:0] seq_5a_s [10];
    int fin_cnt;
    int busy_cnt;

    initial begin
        seq_a5   = '{3'b010, 3'b101, 3'b100, 3'b101, 3'b100, 3'b100, 3'b101,
                     3'b100, 3'b101, 3'b011};
        seq_00   = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100,
                     3'b100, 3'b000, 3'b000};
        seq_ff   = '{3'b101, 3'b101, 3'b101, 3'b101, 3'b101, 3'b101, 3'b101,
                     3'b101, 3'b000, 3'b000};
        seq_01   = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100,
                     3'b101, 3'b000, 3'b000};
        seq_5a_s = '{3'b010, 3'b100, 3'b101, 3'b100, 3'b101, 3'b101, 3'b100,
                     3'b101, 3'b100, 3'b000};

        // Reset state.
        repeat (3) @(negedge clock);
        check_eq("reset_state", 32'(obs()), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check_eq("idle_after_reset", 32'(obs()), 32'd0);

        // A5 with START and STOP: 10 commands, finish in cycle 81.
        start_byte(8'hA5, 1'b1, 1'b1);
        expect_byte("a5_full", seq_a5, 10, 1'b0, 8'h00, 0);
        @(negedge clock);
        check_eq("a5_idle", 32'(obs()), 32'd0);

        // 00 with no framing: eight DATA_0, finish in cycle 65.
        start_byte(8'h00, 1'b0, 1'b0);
        expect_byte("b00_plain", seq_00, 8, 1'b0, 8'hFF, 0);
        @(negedge clock);
        check_eq("b00_idle", 32'(obs()), 32'd0);

        // go held: FF then 01 back to back, one-cycle bit_go gap in DONE.
        start_byte(8'hFF, 1'b0, 1'b0);
        expect_byte("bff_held", seq_ff, 8, 1'b1, 8'h01, 0);
        expect_byte("b01_held", seq_01, 8, 1'b0, 8'h00, 0);
        @(negedge clock);
        check_eq("b01_idle", 32'(obs()), 32'd0);

        // go pulsed mid-byte with 3C: ignored, exactly one finish.
        start_byte(8'h5A, 1'b1, 1'b0);
        expect_byte("b5a_ignore", seq_5a_s, 9, 1'b0, 8'h3C, 30);
        @(negedge clock);
        check_eq("b5a_single_finish", 32'(obs()), 32'd0);

        // bit_finish while bit_go is low is ignored.
        bw_inject = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check_eq($sformatf("inject_idle_%0d", k), 32'(obs()), 32'd0);
        end
        bw_inject = 1'b0;

        // Reset during bit 4 of A5: immediate idle, no finish.
        start_byte(8'hA5, 1'b1, 1'b1);
        for (int k = 1; k <= 44; k++) begin
            @(negedge clock);
            if (k == 1) go = 1'b0;
        end
        check_eq("rst_pre_bitgo", 32'(obs()), 32'(7'b1001_100));
        #2 reset_n = 1'b0;
        #1 check_eq("rst_immediate", 32'(obs()), 32'd0);
        @(negedge clock);
        #2 reset_n = 1'b1;
        fin_cnt  = 0;
        busy_cnt = 0;
        for (int k = 0; k < 90; k++) begin
            @(negedge clock);
            if (finish) fin_cnt++;
            if (busy) busy_cnt++;
        end
        check_eq("rst_no_finish", 32'(fin_cnt), 32'd0);
        check_eq("rst_no_busy", 32'(busy_cnt), 32'd0);
        start_byte(8'hA5, 1'b1, 1'b1);
        expect_byte("a5_after_rst", seq_a5, 10, 1'b0, 8'h00, 0);
        @(negedge clock);
        check_eq("a5_after_rst_idle", 32'(obs()), 32'd0);

`ifdef I2C_WRITE_BYTE_TIMEOUT_EN
        // Missing bit_finish: error 16 cycles after bit_go rises, no finish.
        bw_stall = 1'b1;
        start_byte(8'hA5, 1'b1, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            if (k == 1) go = 1'b0;
            check_eq($sformatf("to_c%0d", k), 32'(obs()), 32'(7'b1001_010));
        end
        @(negedge clock);
        check_eq("to_error", 32'(obs()), 32'(7'b0010_000));
        @(negedge clock);
        check_eq("to_idle", 32'(obs()), 32'd0);
        bw_stall = 1'b0;
        $display("[TB] timeout: error pulse observed in cycle 17");
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
